// File: rtl/decim_pkg.sv
// rtl/decim_pkg.sv - shared widths, output limits and FIFO word type for the decimator output stage
package decim_pkg;

    localparam int IN_WIDTH_DEF  = 50;
    localparam int OUT_WIDTH_DEF = 24;

    localparam logic signed [OUT_WIDTH_DEF-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH_DEF-1){1'b1}}};
    localparam logic signed [OUT_WIDTH_DEF-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH_DEF-1){1'b0}}};

    typedef struct packed {
        logic                            sat;
        logic signed [OUT_WIDTH_DEF-1:0] data;
    } fmt_word_t;

endpackage

// File: rtl/decim_sync_fifo.sv
// rtl/decim_sync_fifo.sv - first-word-fall-through FIFO with registered head word and exact level
module decim_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 25
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_tvalid_i,
    input  logic [WIDTH-1:0]       s_tdata_i,
    input  logic                   m_tready_i,
    output logic [WIDTH-1:0]       m_tdata_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop;
    logic             push_ok;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign pop     = m_tready_i && !empty_o;
    assign push_ok = s_tvalid_i && (!full_o || pop);

    // The head register is loaded with whatever will sit at the read pointer
    // after this edge, bypassing the array when that entry is being written now.
    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop);
        if (level_d == '0) begin
            head_d = '0;
        end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
            head_d = s_tdata_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= s_tdata_i;
        end
    end

    assign m_tdata_o = head_q;
    assign level_o   = level_q;

endmodule

// File: rtl/decim_output_formatter.sv
// rtl/decim_output_formatter.sv - shift/round/saturate the halfband output and buffer it for the host
module decim_output_formatter
    import decim_pkg::*;
#(
    parameter int IN_WIDTH    = IN_WIDTH_DEF,
    parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
    parameter int SHIFT_WIDTH = 6,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [IN_WIDTH-1:0]           in_data,
    input  logic [SHIFT_WIDTH-1:0]        shift,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic                          out_sat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [CNT_WIDTH-1:0]          sat_count
);

    localparam int RW = IN_WIDTH + 1;
    localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT = SHIFT_WIDTH'(IN_WIDTH - 1);
    localparam logic signed [RW-1:0]   LIM_HI    = RW'(OUT_MAX);
    localparam logic signed [RW-1:0]   LIM_LO    = RW'(OUT_MIN);

    logic                   s1_valid_q;
    logic signed [RW-1:0]   s1_r_q, s1_r_d;
    logic [SHIFT_WIDTH-1:0] eff_shift;
    logic signed [RW-1:0]   in_ext;
    logic signed [RW-1:0]   bias;

    logic                   s2_valid_q;
    fmt_word_t              s2_q, s2_d;

    logic [CNT_WIDTH-1:0]   sat_count_q, sat_count_d;
    logic                   overflow_q, overflow_d;

    fmt_word_t              head_w;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   drop;

    // One extra bit of headroom so adding the half-LSB bias can never wrap.
    always_comb begin
        eff_shift = (shift > MAX_SHIFT) ? MAX_SHIFT : shift;
        in_ext    = {in_data[IN_WIDTH-1], in_data};
        bias      = (eff_shift != '0) ? (RW'(1) << (eff_shift - SHIFT_WIDTH'(1))) : '0;
        s1_r_d    = (in_ext + bias) >>> eff_shift;
    end

    always_comb begin
        s2_d = s2_q;
        if (s1_r_q > LIM_HI) begin
            s2_d.sat  = 1'b1;
            s2_d.data = OUT_MAX;
        end else if (s1_r_q < LIM_LO) begin
            s2_d.sat  = 1'b1;
            s2_d.data = OUT_MIN;
        end else begin
            s2_d.sat  = 1'b0;
            s2_d.data = s1_r_q[OUT_WIDTH_DEF-1:0];
        end
    end

    // Dropped samples still count toward saturation statistics.
    always_comb begin
        sat_count_d = sat_count_q;
        if (s1_valid_q && s2_d.sat && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + CNT_WIDTH'(1);
        end
    end

    assign drop = s2_valid_q && fifo_full && !(out_valid && out_ready);

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_q        <= '0;
            sat_count_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_valid_q  <= in_valid;
            s2_valid_q  <= s1_valid_q;
            sat_count_q <= sat_count_d;
            overflow_q  <= overflow_d;
            if (in_valid) begin
                s1_r_q <= s1_r_d;
            end
            if (s1_valid_q) begin
                s2_q <= s2_d;
            end
        end
    end

    decim_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fmt_word_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .s_tvalid_i (s2_valid_q),
        .s_tdata_i  (s2_q),
        .m_tready_i (out_ready),
        .m_tdata_o  (head_w),
        .level_o    (fifo_level),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head_w.data;
    assign out_sat   = head_w.sat;
    assign overflow  = overflow_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_decim_output_formatter.sv
// tb/tb_decim_output_formatter.sv - randomized and directed bench against a transaction-level model
module tb_decim_output_formatter;
    import decim_pkg::*;

    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [49:0]        in_data;
    logic [5:0]         shift;
    logic               out_valid;
    logic               out_ready;
    logic [23:0]        out_data;
    logic               out_sat;
    logic [3:0]         fifo_level;
    logic               overflow;
    logic               clr_overflow;
    logic [15:0]        sat_count;

    int n_cmp = 0;
    int n_err = 0;

    fmt_word_t mq[$];
    logic      d1_v, d2_v;
    fmt_word_t d1_w, d2_w;
    logic      m_ovf;
    int        m_sat;

    decim_output_formatter dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .shift        (shift),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sat      (out_sat),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .sat_count    (sat_count)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Floor division of (x + half) by 2^eff, then clamp to the output range.
    function automatic fmt_word_t ref_fmt(input logic signed [49:0] x, input logic [5:0] sh);
        fmt_word_t r;
        longint xv, eff, den, num, q, hi, lo;
        xv  = x;
        eff = (sh > 6'd49) ? 49 : longint'(sh);
        den = longint'(1) << eff;
        num = xv + ((eff > 0) ? den / 2 : 0);
        q   = num / den;
        if (num < 0 && (num % den) != 0) q = q - 1;
        hi = (longint'(1) << (OUT_WIDTH_DEF - 1)) - 1;
        lo = -(longint'(1) << (OUT_WIDTH_DEF - 1));
        if (q > hi) begin
            r.sat = 1'b1; r.data = OUT_MAX;
        end else if (q < lo) begin
            r.sat = 1'b1; r.data = OUT_MIN;
        end else begin
            r.sat = 1'b0; r.data = OUT_WIDTH_DEF'(q);
        end
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        d1_v = 1'b0; d2_v = 1'b0;
        d1_w = '0;   d2_w = '0;
        m_ovf = 1'b0;
        m_sat = 0;
    endtask

    task automatic model_edge(input logic v, input logic signed [49:0] d, input logic [5:0] sh,
                              input logic rdy, input logic clr);
        logic pop, push, drp;
        pop  = rdy && (mq.size() != 0);
        push = 1'b0;
        drp  = 1'b0;
        if (d2_v) begin
            if (d2_w.sat && m_sat < 65535) m_sat++;
            if (mq.size() < DEPTH || pop) push = 1'b1;
            else drp = 1'b1;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(d2_w);
        if (drp) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        d2_v = d1_v; d2_w = d1_w;
        d1_v = v;    d1_w = ref_fmt(d, sh);
    endtask

    task automatic cycle(input logic v, input logic signed [49:0] d, input logic [5:0] sh,
                         input logic rdy, input logic clr);
        in_valid = v; in_data = d; shift = sh; out_ready = rdy; clr_overflow = clr;
        @(posedge clk);
        model_edge(v, d, sh, rdy, clr);
        #1;
        expect_eq("level", fifo_level, mq.size());
        expect_eq("valid", out_valid, mq.size() != 0);
        expect_eq("overflow", overflow, m_ovf);
        if (mq.size() != 0) begin
            expect_eq("data", out_data, $unsigned(mq[0].data));
            expect_eq("sat", out_sat, mq[0].sat);
        end
        if (!d2_v) expect_eq("sat_count", sat_count, m_sat);
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cycle(1'b0, '0, '0, rdy, 1'b0);
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
        rst = 1'b1;
        #1;
        expect_eq("rst_valid", out_valid, 0);
        expect_eq("rst_data", out_data, 0);
        expect_eq("rst_sat", out_sat, 0);
        expect_eq("rst_level", fifo_level, 0);
        expect_eq("rst_overflow", overflow, 0);
        expect_eq("rst_sat_count", sat_count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    logic [23:0] rnd_exp [4] = '{24'd2, 24'hFFFFFF, 24'd1, 24'hFFFFFE};
    logic [23:0] sat_exp [4] = '{24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h000000};
    logic        satf_exp[4] = '{1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        logic [63:0]        r64;
        logic signed [49:0] rd;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        model_clear();
        #1;
        apply_reset();

        // passthrough and latency
        cycle(1'b1, 50'sd100, 6'd0, 1'b1, 1'b0);
        cycle(1'b1, -50'sd100, 6'd0, 1'b1, 1'b0);
        expect_eq("pt_latency", out_valid, 0);
        cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        expect_eq("pt_first_valid", out_valid, 1);
        expect_eq("pt_first_data", out_data, 24'd100);
        idle(4, 1'b1);

        // round-half-up
        cycle(1'b1, 50'sd24, 6'd4, 1'b0, 1'b0);
        cycle(1'b1, -50'sd24, 6'd4, 1'b0, 1'b0);
        cycle(1'b1, 50'sd23, 6'd4, 1'b0, 1'b0);
        cycle(1'b1, -50'sd25, 6'd4, 1'b0, 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            expect_eq("round_data", out_data, rnd_exp[i]);
            expect_eq("round_sat", out_sat, 0);
            cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        end

        // saturation and shift clamp
        cycle(1'b1, 50'sd1073741824, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, -50'sd1073741824, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 50'sd8388607, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, -50'sd1, 6'd63, 1'b0, 1'b0);
        idle(3, 1'b0);
        expect_eq("sat_count_two", sat_count, 2);
        for (int i = 0; i < 4; i++) begin
            expect_eq("satur_data", out_data, sat_exp[i]);
            expect_eq("satur_flag", out_sat, satf_exp[i]);
            cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        end

        // overflow: 10 pushes into a stalled 8-deep FIFO
        for (int i = 1; i <= 10; i++) cycle(1'b1, 50'(i), 6'd0, 1'b0, 1'b0);
        idle(3, 1'b0);
        expect_eq("ovf_level", fifo_level, 8);
        expect_eq("ovf_flag", overflow, 1);
        for (int i = 1; i <= 8; i++) begin
            expect_eq("ovf_drain", out_data, 24'(i));
            cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        end
        expect_eq("ovf_empty", out_valid, 0);
        cycle(1'b0, '0, 6'd0, 1'b0, 1'b1);
        expect_eq("ovf_clear", overflow, 0);

        // push and pop together while full
        for (int i = 11; i <= 18; i++) cycle(1'b1, 50'(i), 6'd0, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 50'sd20, 6'd0, 1'b0, 1'b0);
        cycle(1'b0, '0, 6'd0, 1'b0, 1'b0);
        cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        expect_eq("full_pp_level", fifo_level, 8);
        expect_eq("full_pp_ovf", overflow, 0);
        for (int i = 0; i < 8; i++) begin
            expect_eq("full_pp_order", out_data, (i < 7) ? 24'(12 + i) : 24'd20);
            cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        end

        // reset with samples buffered and in flight
        for (int i = 21; i <= 25; i++) cycle(1'b1, 50'(i), 6'd0, 1'b0, 1'b0);
        idle(1, 1'b0);
        apply_reset();
        cycle(1'b1, 50'sd7, 6'd0, 1'b1, 1'b0);
        cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        expect_eq("post_rst_lat", out_valid, 0);
        cycle(1'b0, '0, 6'd0, 1'b1, 1'b0);
        expect_eq("post_rst_valid", out_valid, 1);
        expect_eq("post_rst_data", out_data, 24'd7);
        idle(3, 1'b1);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r64 = {$urandom, $urandom};
            rd  = r64[49:0];
            rd  = rd >>> $urandom_range(0, 49);
            cycle($urandom_range(0, 99) < 60, rd, 6'($urandom_range(0, 63)),
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4);
        end
        idle(12, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decim_output_formatter.md
Name: decim_output_formatter

Overview:
- Final stage of the sigma-delta decimation chain. Consumes the 50-bit, 1 kHz output of the second halfband decimator.
- Rescales the sample with a programmable arithmetic right shift and round-half-up, then saturates to the output word width.
- Buffers results in a small FIFO and presents them on a valid/ready interface to the host or serial bridge.
- Reports per-sample saturation, a saturation event count and a sticky FIFO-overflow flag.

Parameters:
- IN_WIDTH, 50, width of the incoming halfband sample (signed)
- OUT_WIDTH, 24, width of the formatted output sample (signed)
- SHIFT_WIDTH, 6, width of the shift control
- FIFO_DEPTH, 8, number of FIFO entries (power of two)
- CNT_WIDTH, 16, width of the saturation counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  sample strobe from upstream halfband stage; no backpressure upstream
- in_data  in  IN_WIDTH  signed input sample
- shift  in  SHIFT_WIDTH  right-shift amount; sampled on in_valid
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head this cycle
- out_data  out  OUT_WIDTH  signed formatted sample at FIFO head
- out_sat  out  1  head sample was saturated
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- clr_overflow  in  1  synchronous clear of overflow
- sat_count  out  CNT_WIDTH  number of saturated samples since reset

Behaviour:
- Reset: rst asserted asynchronously forces out_valid=0, out_data=0, out_sat=0, fifo_level=0, overflow=0 and sat_count=0. It also clears all pipeline valids and the FIFO pointers.
- Reset mid-stream: all in-flight and buffered samples are discarded. The first in_valid after rst deasserts is processed normally.
- Stage 1 (registered, fires on in_valid):
  - eff_shift = min(shift, IN_WIDTH-1).
  - Compute at IN_WIDTH+1 bits: r = (in_data + (eff_shift>0 ? 2^(eff_shift-1) : 0)) >>> eff_shift, with sign extension before the add so the add never wraps.
  - Rounding is round-half-up (toward +inf at exact .5).
- Stage 2 (registered):
  - If r > 2^(OUT_WIDTH-1)-1, output is max positive and sat=1.
  - If r < -2^(OUT_WIDTH-1), output is max negative and sat=1.
  - Otherwise output is r truncated to OUT_WIDTH and sat=0.
  - sat_count increments on each sat=1 and holds at all-ones (no wrap).
- FIFO write occurs at the clock edge ending the stage-2 valid cycle.
- Latency: in_valid at cycle N gives out_valid=1 at cycle N+3 when the FIFO was empty and no pop is pending.
- FIFO organisation: first-word-fall-through with registered out_data/out_sat. Each entry holds {sat, data}.
- Pop occurs when out_valid && out_ready. out_ready while empty has no effect.
- Push while full, no pop that cycle: the incoming sample is dropped, overflow is set, and sat_count still counts it.
- Push and pop in the same cycle while full: both are accepted, the level stays at FIFO_DEPTH, and overflow is not set.
- Push and pop in the same cycle while level=1: the head advances to the new sample with no bubble.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is exact (0..FIFO_DEPTH).
- clr_overflow in the same cycle as a new drop: overflow stays 1 (set wins).
- Throughput: one sample per clock. The upstream rate is far lower, but full-rate back-to-back input is supported.
- A shift change between samples takes effect on the next in_valid. In-flight samples keep the shift captured with them.

Decomposition:
- Shared package decim_pkg holds:
  - IN_WIDTH/OUT_WIDTH defaults
  - OUT_MAX/OUT_MIN constants derived from OUT_WIDTH
  - typedef fmt_word_t {logic sat; logic signed [OUT_WIDTH-1:0] data}
- One natural sub-module, decim_sync_fifo: parameterised depth/width, FWFT, level output, full/empty flags.
- The round/saturate pipeline stays inline in decim_output_formatter.

Test Plan:
- Passthrough: shift=0, in_data=100 then -100, out_ready=1 -> out_data=100 then -100, out_sat=0, out_valid first high 3 cycles after the first in_valid.
- Rounding: shift=4, in_data=24, -24, 23, -25 -> out_data=2, -1, 1, -2; all with out_sat=0.
- Saturation: shift=0, in_data=2^30 then -2^30 then 8388607 -> out_data=0x7FFFFF (sat=1), 0x800000 (sat=1), 0x7FFFFF (sat=0); sat_count=2. Separately, shift=63 clamps to 49 and in_data=-1 gives out_data=0.
- Overflow: out_ready=0, push 10 samples 1..10 -> fifo_level=8 and overflow=1 after the 9th. Then out_ready=1 drains 1..8 in order and samples 9 and 10 are absent. clr_overflow=1 clears the flag.
- Full simultaneous push/pop: fill to 8, then push 20 with out_ready=1 on the same cycle -> overflow stays 0, fifo_level stays 8, and 20 appears after the 7 remaining older samples.
- Reset mid-stream: 5 samples buffered, assert rst for 2 cycles -> out_valid=0 and fifo_level=0 immediately, sat_count=0. The next sample 7 at shift=0 emerges 3 cycles after its in_valid.
